// File: rtl/prog_counter_pkg.sv
// Shared constants for the programmable counter-timer: mode encodings and default widths.
package prog_counter_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_PRESCALE_W = 8;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

endpackage

// File: rtl/prescaler_div.sv
// Programmable divider: tick asserts on the enabled cycle where the divider reaches prescale.
module prescaler_div #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] div_cnt;

  assign tick = en && (div_cnt == prescale);

  // Frozen while en=0; clr has priority and restarts the divide period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tick ? '0 : div_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/prog_counter_timer.sv
// Loadable up/down counter-timer with prescaler, programmable limit, wrap/saturate/one-shot modes.
module prog_counter_timer
  import prog_counter_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      cmp_val,
  input  logic                  out_en,
  output logic [WIDTH-1:0]      count_out,
  output logic [WIDTH-1:0]      oe,
  output logic                  tc_pulse,
  output logic                  cmp_match,
  output logic                  halted
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] bound;
  logic             at_bound;
  logic             tc_nxt;
  logic             halted_nxt;
  logic             tick;
  logic             div_en;

  assign div_en = en && !halted;

  prescaler_div #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (div_en),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );

  assign step_val = dir ? (count - WIDTH'(1)) : (count + WIDTH'(1));
  assign bound    = dir ? '0 : limit;
  // Up-count uses >= so a load above limit is already treated as terminal.
  assign at_bound = dir ? (count == '0) : (count >= limit);

  // Next count / terminal-count / halt decision: load beats tick beats hold.
  always_comb begin
    count_nxt  = count;
    tc_nxt     = 1'b0;
    halted_nxt = halted;
    if (load) begin
      count_nxt  = load_val;
      halted_nxt = 1'b0;
    end else if (tick) begin
      if (!at_bound) begin
        count_nxt = step_val;
        if (step_val == bound) begin
          tc_nxt = 1'b1;
          if (mode == MODE_ONESHOT) begin
            halted_nxt = 1'b1;
          end
        end
      end else begin
        case (mode)
          MODE_SAT:     count_nxt  = count;
          MODE_ONESHOT: halted_nxt = 1'b1;
          default:      count_nxt  = dir ? limit : '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      tc_pulse <= 1'b0;
      halted   <= 1'b0;
    end else begin
      count    <= count_nxt;
      tc_pulse <= tc_nxt;
      halted   <= halted_nxt;
    end
  end

  assign count_out = out_en ? count : '0;
  assign oe        = {WIDTH{out_en}};
  assign cmp_match = (count == cmp_val);

endmodule

// File: tb/tb_prog_counter_timer.sv
// Randomised and directed checking of prog_counter_timer against a behavioural model.
module tb_prog_counter_timer;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 8;
  localparam int          MOD = 1 << W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic          dir = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  limit = '0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  cmp_val = '0;
  logic          out_en = 1'b1;
  logic [W-1:0]  count_out;
  logic [W-1:0]  oe;
  logic          tc_pulse;
  logic          cmp_match;
  logic          halted;

  int checks = 0;
  int errors = 0;

  int m_cnt  = 0;
  int m_pre  = 0;
  bit m_halt = 1'b0;
  bit m_tc   = 1'b0;

  prog_counter_timer #(
    .WIDTH      (W),
    .PRESCALE_W (PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .dir       (dir),
    .mode      (mode),
    .limit     (limit),
    .prescale  (prescale),
    .cmp_val   (cmp_val),
    .out_en    (out_en),
    .count_out (count_out),
    .oe        (oe),
    .tc_pulse  (tc_pulse),
    .cmp_match (cmp_match),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("count_out", 32'(count_out), out_en ? 32'(m_cnt) : 32'd0);
    check_eq("oe",        32'(oe),        out_en ? 32'(MOD - 1) : 32'd0);
    check_eq("tc_pulse",  32'(tc_pulse),  32'(m_tc));
    check_eq("halted",    32'(halted),    32'(m_halt));
    check_eq("cmp_match", 32'(cmp_match), 32'(m_cnt == int'(cmp_val)));
  endtask

  function automatic void model_reset();
    m_cnt  = 0;
    m_pre  = 0;
    m_halt = 1'b0;
    m_tc   = 1'b0;
  endfunction

  // Behavioural effect of one rising edge, from the current inputs and model state.
  function automatic void model_edge();
    bit tick;
    int lim;
    bit wrap_mode;
    tick      = 1'b0;
    lim       = int'(limit);
    wrap_mode = (mode == 2'b00) || (mode == 2'b11);
    m_tc      = 1'b0;
    if (load) begin
      m_cnt  = int'(load_val);
      m_pre  = 0;
      m_halt = 1'b0;
      return;
    end
    if (en && !m_halt) begin
      if (m_pre == int'(prescale)) begin
        m_pre = 0;
        tick  = 1'b1;
      end else begin
        m_pre = (m_pre + 1) % (1 << PW);
      end
    end
    if (!tick) return;
    if (!dir) begin
      if (m_cnt >= lim) begin
        if (wrap_mode) m_cnt = 0;
        else if (mode == 2'b10) m_halt = 1'b1;
      end else begin
        m_cnt = (m_cnt + 1) % MOD;
        if (m_cnt == lim) begin
          m_tc = 1'b1;
          if (mode == 2'b10) m_halt = 1'b1;
        end
      end
    end else begin
      if (m_cnt == 0) begin
        if (wrap_mode) m_cnt = lim;
        else if (mode == 2'b10) m_halt = 1'b1;
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_tc = 1'b1;
          if (mode == 2'b10) m_halt = 1'b1;
        end
      end
    end
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    int wrap_seq[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    int sat_seq[5]  = '{2, 1, 0, 0, 0};

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check_eq("reset_cmp", 32'(cmp_match), 32'd1);
    rst_n = 1'b1;

    // Up, WRAP, limit=5, prescale=0
    en = 1'b1; dir = 1'b0; mode = 2'b00; limit = 8'd5; prescale = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("wrap_seq", 32'(count_out), 32'(wrap_seq[i]));
      check_eq("wrap_tc",  32'(tc_pulse),  32'(wrap_seq[i] == 5));
    end

    // prescale=3: one increment per 4 enabled cycles, en gaps stretch it
    prescale = 8'd3; load_val = '0; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq("pre_seq", 32'(count_out), (i == 4) ? 32'd1 : 32'd0);
    end
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    repeat (3) step();
    check_eq("pre_gap_hold", 32'(count_out), 32'd1);
    step();
    check_eq("pre_gap_tick", 32'(count_out), 32'd2);

    // Down, SAT from 3, then load above limit while counting up
    prescale = '0; dir = 1'b1; mode = 2'b01; load_val = 8'd3; load = 1'b1;
    step();
    load = 1'b0;
    check_eq("sat_load", 32'(count_out), 32'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("sat_seq", 32'(count_out), 32'(sat_seq[i]));
      check_eq("sat_tc",  32'(tc_pulse),  32'(i == 2));
    end
    dir = 1'b0; limit = 8'd100; load_val = 8'd200; load = 1'b1;
    step();
    load = 1'b0;
    repeat (4) begin
      step();
      check_eq("above_limit", 32'(count_out), 32'd200);
      check_eq("above_tc",    32'(tc_pulse),  32'd0);
    end

    // ONESHOT up to 4, frozen, then reload 2
    mode = 2'b10; limit = 8'd4; load_val = '0; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq("os_seq",  32'(count_out), 32'(i));
      check_eq("os_halt", 32'(halted),    32'(i == 4));
    end
    repeat (12) step();
    check_eq("os_frozen", 32'(count_out), 32'd4);
    load_val = 8'd2; load = 1'b1;
    step();
    load = 1'b0;
    check_eq("os_reload_halt", 32'(halted), 32'd0);
    step();
    check_eq("os_re3", 32'(count_out), 32'd3);
    step();
    check_eq("os_re4", 32'(count_out), 32'd4);
    check_eq("os_rehalt", 32'(halted), 32'd1);

    // Load coincident with a tick at the boundary in WRAP
    mode = 2'b00; limit = 8'd5; load_val = 8'd5; load = 1'b1;
    step();
    load_val = 8'd9;
    step();
    load = 1'b0;
    check_eq("load_prio", 32'(count_out), 32'd9);
    check_eq("load_tc",   32'(tc_pulse),  32'd0);

    // Compare match, output gating, async reset
    limit = 8'd255; load_val = 8'd7; load = 1'b1;
    step();
    load = 1'b0; cmp_val = 8'd8;
    #1;
    check_eq("cmp_before", 32'(cmp_match), 32'd0);
    step();
    check_eq("cmp_hit", 32'(cmp_match), 32'd1);
    out_en = 1'b0;
    #1;
    check_eq("gate_count", 32'(count_out), 32'd0);
    check_eq("gate_oe",    32'(oe),        32'd0);
    check_eq("gate_cmp",   32'(cmp_match), 32'd1);
    out_en = 1'b1;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst", 32'(count_out), 32'd0);
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 29) == 0);
      load_val = W'($urandom);
      out_en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) dir = ~dir;
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 59) == 0)
        limit = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      if ($urandom_range(0, 79) == 0) prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) cmp_val = W'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
